// File: rtl/rol_iter.sv
// Iterative rotate-left: one binary-weighted stage (1,2,4,8..) per clock, SHAMT_W stages total.
// Latency: fixed SHAMT_W cycles from accept edge to the cycle with done high; the amount does not shorten it.
// Backpressure: start is only taken when ready (IDLE or DONE); start while busy is ignored.
module rol_iter #(
    parameter int WIDTH   = 16,   // must equal 2**SHAMT_W
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   Rot_In,
    input  logic [SHAMT_W-1:0] Rot_Val,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   Rot_Out
);

    localparam int CNT_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] amt_q, amt_d;
    logic [WIDTH-1:0]   rot_out_q, rot_out_d;

    logic [SHAMT_W-1:0] stage_sh;
    logic [WIDTH-1:0]   stage_val;
    logic               last_stage;

    // State and datapath registers; reset overrides any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            amt_q     <= '0;
            rot_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            amt_q     <= amt_d;
            rot_out_q <= rot_out_d;
        end
    end

    // Current stage: rotate data left by 2**cnt; shift is never zero so both halves are well defined.
    always_comb begin
        stage_sh   = SHAMT_W'(1) << cnt_q;
        stage_val  = (data_q << stage_sh) | (data_q >> (WIDTH - 32'(stage_sh)));
        last_stage = (cnt_q == CNT_W'(SHAMT_W - 1));
    end

    // Next-state and datapath update: accept in IDLE/DONE, one stage per RUN cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        amt_d     = amt_q;
        rot_out_d = rot_out_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    data_d  = Rot_In;
                    amt_d   = Rot_Val;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (amt_q[cnt_q]) begin
                    data_d = stage_val;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (last_stage) begin
                    // Result register only moves here, so it holds through IDLE and the next RUN.
                    rot_out_d = data_d;
                    cnt_d     = '0;
                    state_d   = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded purely from state.
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            S_IDLE: ready = 1'b1;
            S_RUN:  busy  = 1'b1;
            S_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
            end
            default: ready = 1'b0;
        endcase
    end

    assign Rot_Out = rot_out_q;

endmodule

// File: tb/tb_rol_iter.sv
// Directed bench for rol_iter: table of operand/amount/result vectors plus hand-written
// sequences for ignore-while-busy, back-to-back accept and mid-operation reset.
// All inputs are driven 1 time unit after the rising edge and outputs sampled there too.
module tb_rol_iter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] Rot_In;
    logic [3:0]  Rot_Val;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] Rot_Out;

    int n_vec;
    int n_bad;

    typedef struct {
        logic [15:0] in;
        logic [3:0]  amt;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [6];

    rol_iter #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .Rot_In  (Rot_In),
        .Rot_Val (Rot_Val),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .Rot_Out (Rot_Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rotr(input logic [15:0] v, input int n);
        logic [31:0] dbl;
        dbl = {v, v} >> n;
        return dbl[15:0];
    endfunction

    // One complete operation with full latency and handshake checks.
    task automatic run_op(input logic [15:0] in, input logic [3:0] amt, input logic [15:0] exp);
        chk("ready_before_start", {15'b0, ready}, 16'd1);
        start   = 1'b1;
        Rot_In  = in;
        Rot_Val = amt;
        step();
        start   = 1'b0;
        Rot_In  = 16'h0000;
        Rot_Val = 4'd0;
        for (int i = 0; i < 4; i++) begin
            chk("busy_in_run", {15'b0, busy}, 16'd1);
            chk("no_done_in_run", {15'b0, done}, 16'd0);
            step();
        end
        chk("done_pulse", {15'b0, done}, 16'd1);
        chk("ready_in_done", {15'b0, ready}, 16'd1);
        chk("result", Rot_Out, exp);
        step();
        chk("done_one_cycle", {15'b0, done}, 16'd0);
        chk("result_held_idle", Rot_Out, exp);
    endtask

    initial begin
        int pulses;
        n_vec   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        start   = 1'b0;
        Rot_In  = 16'h0000;
        Rot_Val = 4'd0;

        tbl[0] = '{in: 16'h8001, amt: 4'd1,  exp: 16'h0003};
        tbl[1] = '{in: 16'h1234, amt: 4'd4,  exp: 16'h2341};
        tbl[2] = '{in: 16'hABCD, amt: 4'd15, exp: 16'hD5E6};
        tbl[3] = '{in: 16'hBEEF, amt: 4'd0,  exp: 16'hBEEF};
        tbl[4] = '{in: 16'h00F0, amt: 4'd8,  exp: 16'hF000};
        tbl[5] = '{in: 16'h0F00, amt: 4'd2,  exp: 16'h3C00};

        step();
        step();
        chk("rst_ready", {15'b0, ready}, 16'd1);
        chk("rst_busy", {15'b0, busy}, 16'd0);
        chk("rst_done", {15'b0, done}, 16'd0);
        chk("rst_rot_out", Rot_Out, 16'h0000);
        rst = 1'b0;
        step();

        // Table vectors.
        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].in, tbl[i].amt, tbl[i].exp);
        end

        // Sweep every amount on a single set bit, then undo it with a rotate-right.
        for (int n = 0; n < 16; n++) begin
            run_op(16'h0001, 4'(n), 16'h0001 << n);
            chk("roundtrip_rotr", rotr(Rot_Out, n), 16'h0001);
        end

        // start and input changes during RUN are ignored; then back-to-back accept in DONE.
        start   = 1'b1;
        Rot_In  = 16'h00F0;
        Rot_Val = 4'd8;
        step();                                  // accept edge E0
        Rot_In  = 16'hFFFF;
        Rot_Val = 4'd3;                          // start still high while busy
        pulses  = 0;
        step();
        start   = 1'b0;
        Rot_In  = 16'h5555;
        Rot_Val = 4'd7;
        if (done) pulses++;
        step();
        start   = 1'b1;
        Rot_In  = 16'hAAAA;
        if (done) pulses++;
        step();
        start   = 1'b0;
        Rot_In  = 16'h0F00;
        Rot_Val = 4'd2;
        if (done) pulses++;
        chk("busy_ignore_seq", {15'b0, busy}, 16'd1);
        step();                                  // after E4: DONE
        chk("ignore_done", {15'b0, done}, 16'd1);
        chk("ignore_result", Rot_Out, 16'hF000);
        chk("ignore_ready", {15'b0, ready}, 16'd1);
        chk("ignore_no_early_done", 16'(pulses), 16'd0);
        start   = 1'b1;                          // accepted on this DONE edge
        step();
        start   = 1'b0;
        Rot_In  = 16'h0000;
        Rot_Val = 4'd0;
        chk("b2b_busy", {15'b0, busy}, 16'd1);
        chk("b2b_no_done", {15'b0, done}, 16'd0);
        chk("b2b_old_result", Rot_Out, 16'hF000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("b2b_old_held", Rot_Out, 16'hF000);
            chk("b2b_busy_run", {15'b0, busy}, 16'd1);
        end
        step();
        chk("b2b_done", {15'b0, done}, 16'd1);
        chk("b2b_result", Rot_Out, 16'h3C00);
        step();
        chk("b2b_done_ends", {15'b0, done}, 16'd0);

        // Reset during RUN discards the operation.
        start   = 1'b1;
        Rot_In  = 16'h1234;
        Rot_Val = 4'd7;
        step();                                  // E0
        start   = 1'b0;
        step();                                  // E1: stage 1 applied, stage 2 next
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_ready", {15'b0, ready}, 16'd1);
        chk("midrst_busy", {15'b0, busy}, 16'd0);
        chk("midrst_rot_out", Rot_Out, 16'h0000);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) pulses++;
            step();
        end
        chk("midrst_no_done", 16'(pulses), 16'd0);
        chk("midrst_rot_out_held", Rot_Out, 16'h0000);

        // start on the same edge as reset is not captured.
        rst     = 1'b1;
        start   = 1'b1;
        Rot_In  = 16'hFFFF;
        Rot_Val = 4'd3;
        step();
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", {15'b0, busy}, 16'd0);
        chk("rst_start_ready", {15'b0, ready}, 16'd1);
        step();
        chk("rst_start_still_idle", {15'b0, busy}, 16'd0);

        // Normal operation after reset.
        run_op(16'h1234, 4'd7, 16'h1A09);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
